flash_cmd_guard: RTL and testbench



---
 rtl/flash_guard_pkg.sv | 22 ++
 rtl/flash_cmd_guard_init_hold.sv | 24 ++
 rtl/flash_cmd_guard.sv | 141 ++++++++++++++
 tb/tb_flash_cmd_guard.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_guard_pkg.sv
// Shared types and JEDEC command bytes for the PRG flash command guard.
package flash_guard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_U1   = 3'd1,
    ST_U2   = 3'd2,
    ST_PROG = 3'd3,
    ST_E0   = 3'd4,
    ST_E1   = 3'd5,
    ST_E2   = 3'd6
  } state_t;

  localparam logic [7:0] CMD_AA = 8'hAA;
  localparam logic [7:0] CMD_55 = 8'h55;
  localparam logic [7:0] CMD_A0 = 8'hA0;
  localparam logic [7:0] CMD_80 = 8'h80;
  localparam logic [7:0] CMD_30 = 8'h30;
  localparam logic [7:0] CMD_10 = 8'h10;
  localparam logic [7:0] CMD_F0 = 8'hF0;

endpackage

// File: rtl/flash_cmd_guard_init_hold.sv
// init_hold: power-on hold down-counter; done asserts once CYCLES clocks have elapsed after reset.
module init_hold #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic done
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CW'(CYCLES);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/flash_cmd_guard.sv
// JEDEC command sequencer and write gate for the PRG flash.
// Optional abandon-on-idle timeout is built only when FLASH_CMD_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no sequence in progress
// U1    | first unlock (AA@A) seen
// U2    | second unlock (55@B) seen, awaiting command
// PROG  | program armed, next write is the data
// E0    | erase setup (80) seen
// E1    | erase first unlock seen
// E2    | erase second unlock seen, awaiting confirm
module flash_cmd_guard
  import flash_guard_pkg::*;
#(
  parameter int                ADDR_W         = 12,
  parameter logic [ADDR_W-1:0] UNLOCK_A       = 12'hAAA,
  parameter logic [ADDR_W-1:0] UNLOCK_B       = 12'h555,
  parameter int                INIT_CYCLES    = 16,
  parameter int                TIMEOUT_CYCLES = 1024
) (
  input  logic              m2,
  input  logic              reset_n,
  input  logic              prg_write_enabled,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              we_allow,
  output logic              init_done,
  output logic              busy,
  output logic              prog_pulse,
  output logic              erase_pulse,
  output logic              seq_error
);

  state_t state;
  state_t next_state;
  logic   step_ok;
  logic   is_f0;
  logic   fire_prog;
  logic   fire_erase;
  logic   at_a;
  logic   at_b;
  logic   timeout_hit;

  init_hold #(.CYCLES(INIT_CYCLES)) u_init_hold (
    .clk   (m2),
    .rst_n (reset_n),
    .done  (init_done)
  );

  assign at_a = (wr_addr == UNLOCK_A);
  assign at_b = (wr_addr == UNLOCK_B);
  assign busy = (state != ST_IDLE);

  always_comb begin
    step_ok    = 1'b0;
    next_state = ST_IDLE;
    fire_prog  = 1'b0;
    fire_erase = 1'b0;
    is_f0      = (wr_data == CMD_F0) && (state != ST_PROG);
    case (state)
      ST_IDLE: if (at_a && wr_data == CMD_AA) begin step_ok = 1'b1; next_state = ST_U1; end
      ST_U1:   if (at_b && wr_data == CMD_55) begin step_ok = 1'b1; next_state = ST_U2; end
      ST_U2: begin
        if (at_a && wr_data == CMD_A0) begin
          step_ok    = 1'b1;
          next_state = ST_PROG;
        end else if (at_a && wr_data == CMD_80) begin
          step_ok    = 1'b1;
          next_state = ST_E0;
        end
      end
      ST_PROG: begin step_ok = 1'b1; fire_prog = 1'b1; end
      ST_E0:   if (at_a && wr_data == CMD_AA) begin step_ok = 1'b1; next_state = ST_E1; end
      ST_E1:   if (at_b && wr_data == CMD_55) begin step_ok = 1'b1; next_state = ST_E2; end
      ST_E2: begin
        if (wr_data == CMD_30 || (at_a && wr_data == CMD_10)) begin
          step_ok    = 1'b1;
          fire_erase = 1'b1;
        end
      end
      default: ;
    endcase
    // Reset command aborts any sequence except an armed program, where it is plain data.
    if (is_f0) begin
      step_ok    = 1'b1;
      next_state = ST_IDLE;
    end
  end

  assign we_allow = init_done & prg_write_enabled & wr_valid & step_ok;

  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      prog_pulse  <= 1'b0;
      erase_pulse <= 1'b0;
      seq_error   <= 1'b0;
    end else begin
      prog_pulse  <= 1'b0;
      erase_pulse <= 1'b0;
      if (wr_valid && init_done) begin
        if (!prg_write_enabled) begin
          state <= ST_IDLE;
        end else if (step_ok) begin
          state       <= next_state;
          prog_pulse  <= fire_prog;
          erase_pulse <= fire_erase;
          if (is_f0) seq_error <= 1'b0;
        end else begin
          state <= ST_IDLE;
          if (state != ST_IDLE) seq_error <= 1'b1;
        end
      end else if (timeout_hit) begin
        state <= ST_IDLE;
      end
    end
  end

`ifdef FLASH_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] idle_count;

  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      idle_count <= '0;
    end else if (wr_valid || !busy || timeout_hit) begin
      idle_count <= '0;
    end else begin
      idle_count <= idle_count + TW'(1);
    end
  end

  assign timeout_hit = busy && (idle_count == TW'(TIMEOUT_CYCLES - 1));
`else
  // No abandon timer in this build; the parameter stays for interface compatibility.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_flash_cmd_guard.sv
// Directed bench for flash_cmd_guard: hold phase, command table, timeout/persistence, mid-sequence reset.
module tb_flash_cmd_guard;

  logic        m2 = 1'b0;
  logic        reset_n = 1'b0;
  logic        prg_write_enabled = 1'b1;
  logic        wr_valid = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        we_allow, init_done, busy, prog_pulse, erase_pulse, seq_error;

  int n_tests = 0;
  int n_fail  = 0;

  flash_cmd_guard #(
    .ADDR_W(12), .UNLOCK_A(12'hAAA), .UNLOCK_B(12'h555),
    .INIT_CYCLES(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .m2(m2), .reset_n(reset_n), .prg_write_enabled(prg_write_enabled),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .we_allow(we_allow), .init_done(init_done), .busy(busy),
    .prog_pulse(prog_pulse), .erase_pulse(erase_pulse), .seq_error(seq_error)
  );

  always #5 m2 = ~m2;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        pwe;
    logic        allow;
    logic        busy;
    logic        prog;
    logic        erase;
    logic        err;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  task automatic add(input logic [11:0] a, input logic [7:0] d, input logic p,
                     input logic al, input logic bz, input logic pr, input logic er, input logic se);
    vecs[nv] = '{a, d, p, al, bz, pr, er, se};
    nv++;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [7:0] d, input logic p, output logic allow);
    @(negedge m2);
    wr_addr = a;
    wr_data = d;
    prg_write_enabled = p;
    wr_valid = 1'b1;
    #1 allow = we_allow;
    @(posedge m2);
    #1;
    wr_valid = 1'b0;
    prg_write_enabled = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge m2);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic got;

    //       addr     data   pwe al bz pr er se
    add(12'hAAA, 8'hAA, 1, 1, 1, 0, 0, 0);
    add(12'h555, 8'h55, 1, 1, 1, 0, 0, 0);
    add(12'hAAA, 8'hA0, 1, 1, 1, 0, 0, 0);
    add(12'h123, 8'h3C, 1, 1, 0, 1, 0, 0);
    add(12'hAAA, 8'hAA, 1, 1, 1, 0, 0, 0);
    add(12'h555, 8'h55, 1, 1, 1, 0, 0, 0);
    add(12'hAAA, 8'h80, 1, 1, 1, 0, 0, 0);
    add(12'hAAA, 8'hAA, 1, 1, 1, 0, 0, 0);
    add(12'h555, 8'h55, 1, 1, 1, 0, 0, 0);
    add(12'h400, 8'h30, 1, 1, 0, 0, 1, 0);
    add(12'hAAA, 8'hAA, 1, 1, 1, 0, 0, 0);
    add(12'h555, 8'h77, 1, 0, 0, 0, 0, 1);
    add(12'h000, 8'hF0, 1, 1, 0, 0, 0, 0);
    add(12'hAAA, 8'hAA, 0, 0, 0, 0, 0, 0);
    add(12'hAAA, 8'hAA, 1, 1, 1, 0, 0, 0);
    add(12'h555, 8'h55, 1, 1, 1, 0, 0, 0);
    add(12'hAAA, 8'h80, 1, 1, 1, 0, 0, 0);
    add(12'h123, 8'hF0, 1, 1, 0, 0, 0, 0);
    add(12'hAAA, 8'hAA, 1, 1, 1, 0, 0, 0);
    add(12'h555, 8'h55, 1, 1, 1, 0, 0, 0);
    add(12'hAAA, 8'h80, 1, 1, 1, 0, 0, 0);
    add(12'hAAA, 8'hAA, 1, 1, 1, 0, 0, 0);
    add(12'h555, 8'h55, 1, 1, 1, 0, 0, 0);
    add(12'hAAA, 8'h10, 1, 1, 0, 0, 1, 0);
    add(12'hAAA, 8'hAA, 1, 1, 1, 0, 0, 0);
    add(12'h555, 8'h55, 1, 1, 1, 0, 0, 0);
    add(12'hAAA, 8'hA0, 1, 1, 1, 0, 0, 0);
    add(12'h777, 8'hF0, 1, 1, 0, 1, 0, 0);
    add(12'hAAA, 8'hAA, 1, 1, 1, 0, 0, 0);
    add(12'h555, 8'h55, 1, 1, 1, 0, 0, 0);
    add(12'hAAA, 8'h80, 1, 1, 1, 0, 0, 0);
    add(12'hAAA, 8'hAA, 1, 1, 1, 0, 0, 0);
    add(12'h555, 8'h55, 1, 1, 1, 0, 0, 0);
    add(12'h555, 8'h10, 1, 0, 0, 0, 0, 1);
    add(12'hAAA, 8'hAA, 0, 0, 0, 0, 0, 1);
    add(12'hAAA, 8'hAA, 1, 1, 1, 0, 0, 1);
    add(12'hAAA, 8'hAA, 0, 0, 0, 0, 0, 1);
    add(12'h000, 8'hF0, 1, 1, 0, 0, 0, 0);
    add(12'h345, 8'h12, 1, 0, 0, 0, 0, 0);

    // Reset state, asynchronous and with no clock edge needed.
    #12;
    chk("rst init_done", init_done, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst prog_pulse", prog_pulse, 1'b0);
    chk("rst erase_pulse", erase_pulse, 1'b0);
    chk("rst seq_error", seq_error, 1'b0);

    // Hold phase: write at cycle 5 is blocked, init_done rises at edge 16.
    @(posedge m2);
    #2 reset_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge m2);
      if (c == 5) begin
        wr_addr = 12'hAAA;
        wr_data = 8'hAA;
        wr_valid = 1'b1;
        #1 chk("hold we_allow", we_allow, 1'b0);
      end
      @(posedge m2);
      #1;
      wr_valid = 1'b0;
      if (c == 5) chk("hold busy", busy, 1'b0);
      if (c == 15) chk("hold init_done c15", init_done, 1'b0);
      if (c == 16) chk("hold init_done c16", init_done, 1'b1);
    end

    for (int i = 0; i < nv; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].pwe, got);
      chk($sformatf("v%0d we_allow", i), got, vecs[i].allow);
      chk($sformatf("v%0d busy", i), busy, vecs[i].busy);
      chk($sformatf("v%0d prog_pulse", i), prog_pulse, vecs[i].prog);
      chk($sformatf("v%0d erase_pulse", i), erase_pulse, vecs[i].erase);
      chk($sformatf("v%0d seq_error", i), seq_error, vecs[i].err);
    end

`ifdef FLASH_CMD_TIMEOUT_EN
    // Write coinciding with expiry is evaluated against the live state.
    do_write(12'hAAA, 8'hAA, 1'b1, got);
    chk("to AA allow", got, 1'b1);
    idle(7);
    chk("to busy after 7", busy, 1'b1);
    do_write(12'h555, 8'h55, 1'b1, got);
    chk("to coincident allow", got, 1'b1);
    chk("to coincident busy", busy, 1'b1);
    idle(7);
    chk("to busy before expiry", busy, 1'b1);
    idle(1);
    chk("to busy after expiry", busy, 1'b0);
    chk("to no seq_error", seq_error, 1'b0);
    do_write(12'hAAA, 8'hA0, 1'b1, got);
    chk("to stale step rejected", got, 1'b0);
    chk("to stale seq_error", seq_error, 1'b0);
    do_write(12'hAAA, 8'hAA, 1'b1, got);
    do_write(12'h555, 8'h55, 1'b1, got);
`else
    // Without the timer a partial sequence survives a long idle gap.
    do_write(12'hAAA, 8'hAA, 1'b1, got);
    chk("persist AA allow", got, 1'b1);
    idle(20);
    chk("persist busy", busy, 1'b1);
    do_write(12'h555, 8'h55, 1'b1, got);
    chk("persist 55 allow", got, 1'b1);
`endif
    chk("u2 busy", busy, 1'b1);

    // Reset mid-sequence: immediate IDLE and a fresh hold phase.
    #2 reset_n = 1'b0;
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst init_done", init_done, 1'b0);
    @(posedge m2);
    #2 reset_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge m2);
      #1;
      if (c == 15) chk("rehold init_done c15", init_done, 1'b0);
      if (c == 16) chk("rehold init_done c16", init_done, 1'b1);
    end
    do_write(12'hAAA, 8'h80, 1'b1, got);
    chk("after rst idle step rejected", got, 1'b0);
    chk("after rst seq_error", seq_error, 1'b0);
    do_write(12'hAAA, 8'hAA, 1'b1, got);
    chk("after rst AA allow", got, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
